// File: rtl/fifo_multi_ctl_if.sv
// Handshake bundle for fifo_multi_ctl: multicast write side, selectable read side,
// and per-channel status flags.
interface fifo_multi_ctl_if #(
  parameter int n = 8,
  parameter int m = 16,
  parameter int o = 4
);
  localparam int w = $clog2(m) + 1;
  localparam int a = $clog2(o);

  logic           latch;
  logic [n-1:0]   data;
  logic [o-1:0]   addr;
  logic           rdy;
  logic [a-1:0]   addr_o;
  logic           pop;
  logic [n-1:0]   data_o;
  logic           valid_o;
  logic [w*o-1:0] status;
  logic [o-1:0]   full;
  logic [o-1:0]   empty;
  logic [o-1:0]   ovf;
  logic [o-1:0]   clr_ovf;

  modport master (
    output latch, data, addr, addr_o, pop, clr_ovf,
    input  rdy, data_o, valid_o, status, full, empty, ovf
  );

  modport slave (
    input  latch, data, addr, addr_o, pop, clr_ovf,
    output rdy, data_o, valid_o, status, full, empty, ovf
  );
endinterface

// File: rtl/fifo_multi_ctl.sv
// Multi-channel FIFO bank: edge-triggered multicast write, one selectable registered
// read port, per-channel fill/full/empty/sticky-overflow, drop-new or overwrite-oldest.
module fifo_multi_ctl #(
  parameter int n   = 8,
  parameter int m   = 16,
  parameter int o   = 4,
  parameter int OVW = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  fifo_multi_ctl_if.slave  bus
);
  localparam int w  = $clog2(m) + 1;
  localparam int a  = $clog2(o);
  localparam int pw = $clog2(m);

  logic             latch_q;
  logic             wr;
  logic [w-1:0]     cnt      [o];
  logic [w-1:0]     cnt_nxt  [o];
  logic [pw-1:0]    wr_ptr   [o];
  logic [pw-1:0]    wr_nxt   [o];
  logic [pw-1:0]    rd_ptr   [o];
  logic [pw-1:0]    rd_nxt   [o];
  logic [n-1:0]     mem      [o][m];
  logic [n-1:0]     head_nxt [o];
  logic [o-1:0]     we, re, is_full, store, ovf_set, rd_adv;
  logic [o-1:0]     ovf_q;
  logic [n-1:0]     data_q;
  logic             valid_q;
  logic [n-1:0]     sel_head;
  logic [w-1:0]     sel_cnt;
  logic             rdy_all;

  always_comb begin
    wr = bus.latch & ~latch_q;
    we = '0; re = '0; is_full = '0; store = '0; ovf_set = '0; rd_adv = '0;
    for (int unsigned i = 0; i < o; i++) begin
      is_full[i] = (cnt[i] == w'(m));
      we[i]      = wr & bus.addr[i];
      re[i]      = bus.pop & (bus.addr_o == a'(i)) & (cnt[i] != '0);
      ovf_set[i] = we[i] & is_full[i] & ~re[i];
      store[i]   = we[i] & (~is_full[i] | re[i] | (OVW != 0));
      // overwrite-oldest retires the head so the new word becomes the tail
      rd_adv[i]  = re[i] | (ovf_set[i] & (OVW != 0));
      wr_nxt[i]  = store[i]  ? wr_ptr[i] + pw'(1) : wr_ptr[i];
      rd_nxt[i]  = rd_adv[i] ? rd_ptr[i] + pw'(1) : rd_ptr[i];
      case ({store[i], rd_adv[i]})
        2'b10:   cnt_nxt[i] = cnt[i] + w'(1);
        2'b01:   cnt_nxt[i] = cnt[i] - w'(1);
        default: cnt_nxt[i] = cnt[i];
      endcase
      // the word landing this edge is not in mem yet; forward it when it is the new head
      head_nxt[i] = (store[i] && (rd_nxt[i] == wr_ptr[i])) ? bus.data
                                                           : mem[i][rd_nxt[i]];
    end
  end

  always_comb begin
    sel_head = '0;
    sel_cnt  = '0;
    rdy_all  = 1'b1;
    for (int unsigned i = 0; i < o; i++) begin
      if (bus.addr_o == a'(i)) begin
        sel_head = head_nxt[i];
        sel_cnt  = cnt_nxt[i];
      end
      rdy_all = rdy_all & (~bus.addr[i] | ~is_full[i]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      latch_q <= 1'b0;
      ovf_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      for (int unsigned i = 0; i < o; i++) begin
        cnt[i]    <= '0;
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
      end
    end else begin
      latch_q <= bus.latch;
      ovf_q   <= ovf_set | (ovf_q & ~bus.clr_ovf);
      valid_q <= (sel_cnt != '0);
      if (sel_cnt != '0) data_q <= sel_head;
      for (int unsigned i = 0; i < o; i++) begin
        cnt[i]    <= cnt_nxt[i];
        wr_ptr[i] <= wr_nxt[i];
        rd_ptr[i] <= rd_nxt[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < o; i++) begin
      if (store[i]) mem[i][wr_ptr[i]] <= bus.data;
    end
  end

  always_comb begin
    bus.status = '0;
    for (int unsigned i = 0; i < o; i++) begin
      bus.status[w*i +: w] = cnt[i];
    end
  end

  assign bus.full    = is_full;
  always_comb begin
    bus.empty = '0;
    for (int unsigned i = 0; i < o; i++) bus.empty[i] = (cnt[i] == '0);
  end
  assign bus.ovf     = ovf_q;
  assign bus.rdy     = (OVW != 0) ? 1'b1 : rdy_all;
  assign bus.data_o  = data_q;
  assign bus.valid_o = valid_q;
endmodule

// File: tb/tb_fifo_multi_ctl.sv
// Bench for fifo_multi_ctl: one drop-new and one overwrite-oldest instance driven
// from the same stimulus; vector table plus scoreboarded multi-cycle sequences.
module tb_fifo_multi_ctl;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       latch = 1'b0;
  logic [7:0] data = '0;
  logic [3:0] addr = '0;
  logic [1:0] addr_o = '0;
  logic       pop = 1'b0;
  logic [3:0] clr_ovf = '0;

  always #5 clk = ~clk;

  fifo_multi_ctl_if #(.n(8), .m(16), .o(4)) bus0 ();
  fifo_multi_ctl_if #(.n(8), .m(16), .o(4)) bus1 ();

  assign bus0.latch = latch;   assign bus1.latch = latch;
  assign bus0.data = data;     assign bus1.data = data;
  assign bus0.addr = addr;     assign bus1.addr = addr;
  assign bus0.addr_o = addr_o; assign bus1.addr_o = addr_o;
  assign bus0.pop = pop;       assign bus1.pop = pop;
  assign bus0.clr_ovf = clr_ovf; assign bus1.clr_ovf = clr_ovf;

  fifo_multi_ctl #(.n(8), .m(16), .o(4), .OVW(0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0.slave));
  fifo_multi_ctl #(.n(8), .m(16), .o(4), .OVW(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1.slave));

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic       rst;
    logic       latch;
    logic [7:0] data;
    logic [3:0] addr;
    logic [1:0] addr_o;
    logic       pop;
    logic [19:0] exp_status;
    logic       exp_valid;
    logic [7:0] exp_data;
    logic       exp_rdy;
  } vec_t;

  vec_t vecs[13];
  logic [7:0] q0[$];
  logic [7:0] q1[$];

  function automatic logic [19:0] st4(input int c0, input int c1, input int c2, input int c3);
    return {5'(c3), 5'(c2), 5'(c1), 5'(c0)};
  endfunction

  function automatic vec_t mk(input logic r, input logic l, input logic [7:0] d, input logic [3:0] ad,
                              input logic [1:0] ao, input logic p, input logic [19:0] es,
                              input logic ev, input logic [7:0] ed, input logic er);
    vec_t v;
    v.rst = r; v.latch = l; v.data = d; v.addr = ad; v.addr_o = ao; v.pop = p;
    v.exp_status = es; v.exp_valid = ev; v.exp_data = ed; v.exp_rdy = er;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    latch = 1'b0; data = '0; addr = '0; addr_o = '0; pop = 1'b0; clr_ovf = '0;
    @(posedge clk);
    #1 rst_n = 1'b0;
    #10 rst_n = 1'b1;
  endtask

  initial begin
    // multicast + single write per latch level, then ordering on channel 3
    vecs[0]  = mk(0, 1, 8'd4, 4'b0011, 2'd1, 0, st4(1,1,0,0), 1, 8'd4, 1);
    vecs[1]  = mk(0, 1, 8'd4, 4'b0011, 2'd1, 0, st4(1,1,0,0), 1, 8'd4, 1);
    vecs[2]  = mk(0, 0, 8'd4, 4'b0011, 2'd1, 0, st4(1,1,0,0), 1, 8'd4, 1);
    vecs[3]  = mk(0, 0, 8'd4, 4'b0011, 2'd2, 0, st4(1,1,0,0), 0, 8'd4, 1);
    vecs[4]  = mk(1, 1, 8'd4, 4'b1111, 2'd3, 0, st4(1,1,1,1), 1, 8'd4, 1);
    vecs[5]  = mk(0, 0, 8'd4, 4'b1111, 2'd3, 0, st4(1,1,1,1), 1, 8'd4, 1);
    vecs[6]  = mk(0, 1, 8'd2, 4'b1111, 2'd3, 0, st4(2,2,2,2), 1, 8'd4, 1);
    vecs[7]  = mk(0, 0, 8'd2, 4'b1111, 2'd3, 0, st4(2,2,2,2), 1, 8'd4, 1);
    vecs[8]  = mk(0, 1, 8'd1, 4'b1111, 2'd3, 0, st4(3,3,3,3), 1, 8'd4, 1);
    vecs[9]  = mk(0, 0, 8'd1, 4'b1111, 2'd3, 1, st4(3,3,3,2), 1, 8'd2, 1);
    vecs[10] = mk(0, 0, 8'd1, 4'b1111, 2'd3, 1, st4(3,3,3,1), 1, 8'd1, 1);
    vecs[11] = mk(0, 0, 8'd1, 4'b1111, 2'd3, 1, st4(3,3,3,0), 0, 8'd1, 1);
    vecs[12] = mk(0, 0, 8'd1, 4'b1111, 2'd3, 1, st4(3,3,3,0), 0, 8'd1, 1);

    #1;
    #10 rst_n = 1'b1;
    chk("reset_status", bus0.status, 32'h0);
    chk("reset_empty", bus0.empty, 32'hF);
    chk("reset_full", bus0.full, 32'h0);
    chk("reset_valid", bus0.valid_o, 32'h0);
    chk("reset_data_o", bus0.data_o, 32'h0);
    chk("reset_ovf", bus0.ovf, 32'h0);

    for (int i = 0; i < 13; i++) begin
      if (vecs[i].rst) do_reset();
      latch = vecs[i].latch; data = vecs[i].data; addr = vecs[i].addr;
      addr_o = vecs[i].addr_o; pop = vecs[i].pop;
      tick();
      chk($sformatf("vec%0d_status0", i), bus0.status, vecs[i].exp_status);
      chk($sformatf("vec%0d_status1", i), bus1.status, vecs[i].exp_status);
      chk($sformatf("vec%0d_valid0", i), bus0.valid_o, vecs[i].exp_valid);
      chk($sformatf("vec%0d_valid1", i), bus1.valid_o, vecs[i].exp_valid);
      chk($sformatf("vec%0d_data0", i), bus0.data_o, vecs[i].exp_data);
      chk($sformatf("vec%0d_data1", i), bus1.data_o, vecs[i].exp_data);
      chk($sformatf("vec%0d_rdy0", i), bus0.rdy, vecs[i].exp_rdy);
    end
    pop = 1'b0;

    // 17 writes into channel 0: drop-new vs overwrite-oldest
    do_reset();
    addr = 4'b0001; addr_o = 2'd0;
    for (int k = 0; k <= 16; k++) begin
      latch = 1'b1; data = 8'(k);
      if (q0.size() < 16) q0.push_back(8'(k));
      q1.push_back(8'(k));
      if (q1.size() > 16) void'(q1.pop_front());
      tick();
      latch = 1'b0;
      tick();
    end
    chk("ovw0_count", bus0.status[4:0], 32'd16);
    chk("ovw1_count", bus1.status[4:0], 32'd16);
    chk("ovw0_full", bus0.full, 32'h1);
    chk("ovw0_empty", bus0.empty, 32'hE);
    chk("ovw0_ovf", bus0.ovf, 32'h1);
    chk("ovw1_ovf", bus1.ovf, 32'h1);
    chk("ovw0_rdy_full", bus0.rdy, 32'h0);
    chk("ovw1_rdy_full", bus1.rdy, 32'h1);
    addr = 4'b0010; #1;
    chk("ovw0_rdy_other", bus0.rdy, 32'h1);
    addr = 4'b0000; #1;
    chk("ovw0_rdy_nomask", bus0.rdy, 32'h1);
    for (int k = 0; k < 16; k++) begin
      chk($sformatf("pop%0d_valid0", k), bus0.valid_o, 32'h1);
      chk($sformatf("pop%0d_valid1", k), bus1.valid_o, 32'h1);
      chk($sformatf("pop%0d_data0", k), bus0.data_o, q0.pop_front());
      chk($sformatf("pop%0d_data1", k), bus1.data_o, q1.pop_front());
      pop = 1'b1;
      tick();
      pop = 1'b0;
    end
    chk("drain_valid0", bus0.valid_o, 32'h0);
    chk("drain_valid1", bus1.valid_o, 32'h0);
    chk("drain_count0", bus0.status[4:0], 32'd0);
    chk("drain_count1", bus1.status[4:0], 32'd0);
    clr_ovf = 4'b0001;
    tick();
    clr_ovf = '0;
    chk("clr_ovf0", bus0.ovf, 32'h0);
    chk("clr_ovf1", bus1.ovf, 32'h0);

    // full channel: write and pop in the same cycle
    do_reset();
    addr = 4'b0001; addr_o = 2'd0;
    for (int k = 0; k < 16; k++) begin
      latch = 1'b1; data = 8'(100 + k);
      tick();
      latch = 1'b0;
      tick();
    end
    latch = 1'b1; data = 8'd200; pop = 1'b1;
    tick();
    latch = 1'b0; pop = 1'b0;
    chk("fullwp_count0", bus0.status[4:0], 32'd16);
    chk("fullwp_count1", bus1.status[4:0], 32'd16);
    chk("fullwp_ovf0", bus0.ovf, 32'h0);
    chk("fullwp_ovf1", bus1.ovf, 32'h0);
    chk("fullwp_head0", bus0.data_o, 32'd101);
    chk("fullwp_head1", bus1.data_o, 32'd101);
    tick();

    // empty channel: write and pop in the same cycle
    addr = 4'b0010; addr_o = 2'd1; latch = 1'b1; data = 8'd55; pop = 1'b1;
    tick();
    latch = 1'b0; pop = 1'b0;
    chk("emptywp_count0", bus0.status[9:5], 32'd1);
    chk("emptywp_valid0", bus0.valid_o, 32'h1);
    chk("emptywp_data0", bus0.data_o, 32'd55);
    chk("emptywp_ovf0", bus0.ovf, 32'h0);

    // reset in the middle of a stream on channel 2
    do_reset();
    addr = 4'b0100; addr_o = 2'd2;
    for (int k = 0; k < 5; k++) begin
      latch = 1'b1; data = 8'(11 + k);
      tick();
      latch = 1'b0;
      tick();
    end
    chk("mid_count", bus0.status[14:10], 32'd5);
    chk("mid_head", bus0.data_o, 32'd11);
    #3 rst_n = 1'b0;
    #1;
    chk("midrst_status0", bus0.status, 32'h0);
    chk("midrst_status1", bus1.status, 32'h0);
    chk("midrst_empty", bus0.empty, 32'hF);
    chk("midrst_valid", bus0.valid_o, 32'h0);
    chk("midrst_data_o", bus0.data_o, 32'h0);
    latch = 1'b1; data = 8'd77;
    #10 rst_n = 1'b1;
    tick();
    chk("relwr_count", bus0.status[14:10], 32'd1);
    chk("relwr_head", bus0.data_o, 32'd77);
    chk("relwr_valid", bus0.valid_o, 32'h1);
    tick();
    latch = 1'b0;
    tick();
    chk("relwr_once", bus0.status[14:10], 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
